// File: rtl/adc_seq_serializer.sv
// Multi-channel parallel-ADC read sequencer with 3-wire serial output to the DSP.
// Optional even-parity trailer bit per word when ADC_SEQ_PARITY_EN is defined.
module adc_seq_serializer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned RD_LOW_CYC = 2,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] db,
    output logic [NUM_CH-1:0] cs_bar,
    output logic              rd_bar,
    output logic              sclk,
    output logic              mosi,
    output logic              busy,
    output logic              overrun
);

`ifdef ADC_SEQ_PARITY_EN
    localparam int unsigned BITS = DATA_W + 1;
`else
    localparam int unsigned BITS = DATA_W;
`endif
    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BitW = $clog2(BITS + 1);

    localparam logic [3:0]      RdLast  = 4'(RD_LOW_CYC - 1);
    localparam logic [3:0]      DivLast = 4'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(BITS - 1);
    localparam logic [ChW-1:0]  ChLast  = ChW'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StRd, StShiftLo, StShiftHi} state_e;

    state_e            state_q, state_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [3:0]        cyc_q, cyc_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [BITS-1:0]   shreg_q, shreg_d;
    logic [NUM_CH-1:0] cs_bar_q, cs_bar_d;
    logic              rd_bar_q, rd_bar_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [BITS-1:0]   load_seq;

    // Word rearranged into transmit order: bit 0 of the result goes out first.
    function automatic logic [BITS-1:0] tx_order(input logic [DATA_W-1:0] w);
        logic [BITS-1:0] s;
        s = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            s[i] = (MSB_FIRST != 0) ? w[int'(DATA_W) - 1 - i] : w[i];
        end
`ifdef ADC_SEQ_PARITY_EN
        s[BITS-1] = ^w;
`endif
        return s;
    endfunction

    function automatic logic [NUM_CH-1:0] cs_sel(input logic [ChW-1:0] ch);
        logic [NUM_CH-1:0] s;
        s = '1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            s[i] = (int'(ch) != i);
        end
        return s;
    endfunction

    assign load_seq = tx_order(db);

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        cs_bar_d  = cs_bar_q;
        rd_bar_d  = rd_bar_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        overrun_d = enable & busy_q;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StRd;
                    ch_d     = '0;
                    cyc_d    = '0;
                    bit_d    = '0;
                    cs_bar_d = cs_sel('0);
                    rd_bar_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            StRd: begin
                if (cyc_q == RdLast) begin
                    // db is captured on the edge that ends the strobe
                    cyc_d    = '0;
                    shreg_d  = load_seq >> 1;
                    mosi_d   = load_seq[0];
                    cs_bar_d = '1;
                    rd_bar_d = 1'b1;
                    sclk_d   = 1'b0;
                    state_d  = StShiftLo;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end

            StShiftLo: begin
                if (cyc_q == DivLast) begin
                    cyc_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StShiftHi;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end

            StShiftHi: begin
                if (cyc_q == DivLast) begin
                    cyc_d = '0;
                    if (bit_q != BitLast) begin
                        bit_d   = bit_q + BitW'(1);
                        mosi_d  = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        sclk_d  = 1'b0;
                        state_d = StShiftLo;
                    end else begin
                        bit_d = '0;
                        if (ch_q != ChLast) begin
                            ch_d     = ch_q + ChW'(1);
                            cs_bar_d = cs_sel(ch_q + ChW'(1));
                            rd_bar_d = 1'b0;
                            state_d  = StRd;
                        end else begin
                            busy_d  = 1'b0;
                            mosi_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            cyc_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            cs_bar_q  <= '1;
            rd_bar_q  <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            cs_bar_q  <= cs_bar_d;
            rd_bar_q  <= rd_bar_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign cs_bar  = cs_bar_q;
    assign rd_bar  = rd_bar_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
